// File: rtl/dma_job_arbiter.sv
// Round-robin arbiter sharing one DMA engine between two AFU requesters.
// Sequences go / done hold-off / done wait / completion and gates the stream channels to the owner.
module dma_job_arbiter #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int GO_HOLDOFF = 2,
  parameter int CYC_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // requester 0
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [ADDR_WIDTH-1:0] i_req0_rd_addr,
  input  logic [ADDR_WIDTH:0]   i_req0_rd_size,
  input  logic [ADDR_WIDTH-1:0] i_req0_wr_addr,
  input  logic [ADDR_WIDTH:0]   i_req0_wr_size,
  output logic                  o_req0_cmpl,
  input  logic                  i_req0_rd_en,
  output logic                  o_req0_empty,
  input  logic                  i_req0_wr_en,
  output logic                  o_req0_full,
  input  logic [DATA_WIDTH-1:0] i_req0_wr_data,
  // requester 1
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [ADDR_WIDTH-1:0] i_req1_rd_addr,
  input  logic [ADDR_WIDTH:0]   i_req1_rd_size,
  input  logic [ADDR_WIDTH-1:0] i_req1_wr_addr,
  input  logic [ADDR_WIDTH:0]   i_req1_wr_size,
  output logic                  o_req1_cmpl,
  input  logic                  i_req1_rd_en,
  output logic                  o_req1_empty,
  input  logic                  i_req1_wr_en,
  output logic                  o_req1_full,
  input  logic [DATA_WIDTH-1:0] i_req1_wr_data,
  // shared read data
  input  logic [DATA_WIDTH-1:0] i_dma_rd_data,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  // DMA engine
  output logic                  o_dma_rd_go,
  output logic                  o_dma_wr_go,
  output logic [ADDR_WIDTH-1:0] o_dma_rd_addr,
  output logic [ADDR_WIDTH:0]   o_dma_rd_size,
  output logic [ADDR_WIDTH-1:0] o_dma_wr_addr,
  output logic [ADDR_WIDTH:0]   o_dma_wr_size,
  input  logic                  i_dma_rd_done,
  input  logic                  i_dma_wr_done,
  output logic                  o_dma_rd_en,
  output logic                  o_dma_wr_en,
  input  logic                  i_dma_empty,
  input  logic                  i_dma_full,
  output logic [DATA_WIDTH-1:0] o_dma_wr_data,
  // status
  output logic                  o_busy,
  output logic                  o_owner,
  output logic [CYC_WIDTH-1:0]  o_job_cycles
);

  // state | meaning
  // IDLE  | waiting for a request; ready offered to the granted requester
  // GO    | one-cycle go pulses for non-zero channels
  // HOLD  | GO_HOLDOFF cycles; stale engine done levels ignored
  // BUSY  | waiting for done on every channel with non-zero size
  // CMPL  | one-cycle completion pulse to the owner; priority flips
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GO   = 3'd1,
    S_HOLD = 3'd2,
    S_BUSY = 3'd3,
    S_CMPL = 3'd4
  } state_t;

  localparam int HOLD_W = (GO_HOLDOFF > 1) ? $clog2(GO_HOLDOFF) : 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_prio;
  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_rd_size;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH:0]   r_wr_size;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [CYC_WIDTH-1:0]  r_cyc_cnt;

  logic w_grant;
  logic w_accept;
  logic w_active;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_grant  = (i_req0_valid && i_req1_valid) ? r_prio : i_req1_valid;
  assign w_accept = (r_state == S_IDLE) && (i_req0_valid || i_req1_valid);
  assign w_active = (r_state == S_GO) || (r_state == S_HOLD) || (r_state == S_BUSY);
  assign w_rd_ok  = (r_rd_size == '0) || i_dma_rd_done;
  assign w_wr_ok  = (r_wr_size == '0) || i_dma_wr_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_owner    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_size  <= '0;
      r_wr_addr  <= '0;
      r_wr_size  <= '0;
      r_hold_cnt <= '0;
      r_cyc_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner   <= w_grant;
        r_rd_addr <= w_grant ? i_req1_rd_addr : i_req0_rd_addr;
        r_rd_size <= w_grant ? i_req1_rd_size : i_req0_rd_size;
        r_wr_addr <= w_grant ? i_req1_wr_addr : i_req0_wr_addr;
        r_wr_size <= w_grant ? i_req1_wr_size : i_req0_wr_size;
        r_cyc_cnt <= '0;
      end else if (w_active && (r_cyc_cnt != '1)) begin
        r_cyc_cnt <= r_cyc_cnt + 1'b1;
      end
      // hold-off timer: loaded in GO, terminal count ends HOLD
      if (r_state == S_GO) begin
        r_hold_cnt <= HOLD_W'(GO_HOLDOFF - 1);
      end else if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      if (r_state == S_CMPL) begin
        r_prio <= ~r_owner;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_dma_rd_go  = 1'b0;
    o_dma_wr_go  = 1'b0;
    o_req0_cmpl  = 1'b0;
    o_req1_cmpl  = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req0_ready = i_req0_valid && !w_grant;
        o_req1_ready = i_req1_valid && w_grant;
        if (w_accept) w_state_nxt = S_GO;
      end
      S_GO: begin
        o_dma_rd_go = (r_rd_size != '0);
        o_dma_wr_go = (r_wr_size != '0);
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_rd_ok && w_wr_ok) w_state_nxt = S_CMPL;
      end
      S_CMPL: begin
        o_req0_cmpl = !r_owner;
        o_req1_cmpl = r_owner;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // stream channels reach the engine only from the owner during an active job
  assign o_req0_empty  = (w_active && !r_owner) ? i_dma_empty : 1'b1;
  assign o_req0_full   = (w_active && !r_owner) ? i_dma_full  : 1'b1;
  assign o_req1_empty  = (w_active && r_owner)  ? i_dma_empty : 1'b1;
  assign o_req1_full   = (w_active && r_owner)  ? i_dma_full  : 1'b1;
  assign o_dma_rd_en   = w_active && (r_owner ? i_req1_rd_en : i_req0_rd_en);
  assign o_dma_wr_en   = w_active && (r_owner ? i_req1_wr_en : i_req0_wr_en);
  assign o_dma_wr_data = r_owner ? i_req1_wr_data : i_req0_wr_data;
  assign o_rd_data     = i_dma_rd_data;

  assign o_dma_rd_addr = r_rd_addr;
  assign o_dma_rd_size = r_rd_size;
  assign o_dma_wr_addr = r_wr_addr;
  assign o_dma_wr_size = r_wr_size;
  assign o_busy        = (r_state != S_IDLE);
  assign o_owner       = r_owner;
  assign o_job_cycles  = r_cyc_cnt;

endmodule

// File: tb/tb_dma_job_arbiter.sv
// Self-checking bench for dma_job_arbiter: a behavioural engine plus a cycle-arithmetic job model.
// Inputs are driven and outputs sampled just after the falling edge.
module tb_dma_job_arbiter;
  localparam int AW = 42;
  localparam int DW = 64;
  localparam int G  = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          v    [2];
  logic          rdy  [2];
  logic [AW-1:0] ra   [2];
  logic [AW:0]   rs   [2];
  logic [AW-1:0] wa   [2];
  logic [AW:0]   ws   [2];
  logic          cmpl [2];
  logic          ren  [2];
  logic          emp  [2];
  logic          wen  [2];
  logic          ful  [2];
  logic [DW-1:0] wd   [2];
  logic [DW-1:0] e_rd_data, rd_data;
  logic          rd_go, wr_go;
  logic [AW-1:0] d_ra, d_wa;
  logic [AW:0]   d_rs, d_ws;
  logic          rd_done, wr_done;
  logic          d_ren, d_wen, d_empty, d_full;
  logic [DW-1:0] d_wd;
  logic          busy, owner;
  logic [CW-1:0] jc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // engine: done drops when go is seen, rises lat cycles later, then holds
  int   lat_rd = 1, lat_wr = 1;
  int   rd_cnt = 0, wr_cnt = 0;
  logic auto_rd = 1'b0, auto_wr = 1'b0;
  logic man_mode = 1'b0, man_rd = 1'b0, man_wr = 1'b0;
  always @(posedge clk) begin
    if (rd_go) begin
      auto_rd <= 1'b0; rd_cnt <= lat_rd;
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1) auto_rd <= 1'b1;
    end
    if (wr_go) begin
      auto_wr <= 1'b0; wr_cnt <= lat_wr;
    end else if (wr_cnt != 0) begin
      wr_cnt <= wr_cnt - 1;
      if (wr_cnt == 1) auto_wr <= 1'b1;
    end
  end
  assign rd_done = man_mode ? man_rd : auto_rd;
  assign wr_done = man_mode ? man_wr : auto_wr;

  dma_job_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GO_HOLDOFF(G), .CYC_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v[0]), .o_req0_ready(rdy[0]),
    .i_req0_rd_addr(ra[0]), .i_req0_rd_size(rs[0]),
    .i_req0_wr_addr(wa[0]), .i_req0_wr_size(ws[0]),
    .o_req0_cmpl(cmpl[0]), .i_req0_rd_en(ren[0]), .o_req0_empty(emp[0]),
    .i_req0_wr_en(wen[0]), .o_req0_full(ful[0]), .i_req0_wr_data(wd[0]),
    .i_req1_valid(v[1]), .o_req1_ready(rdy[1]),
    .i_req1_rd_addr(ra[1]), .i_req1_rd_size(rs[1]),
    .i_req1_wr_addr(wa[1]), .i_req1_wr_size(ws[1]),
    .o_req1_cmpl(cmpl[1]), .i_req1_rd_en(ren[1]), .o_req1_empty(emp[1]),
    .i_req1_wr_en(wen[1]), .o_req1_full(ful[1]), .i_req1_wr_data(wd[1]),
    .i_dma_rd_data(e_rd_data), .o_rd_data(rd_data),
    .o_dma_rd_go(rd_go), .o_dma_wr_go(wr_go),
    .o_dma_rd_addr(d_ra), .o_dma_rd_size(d_rs),
    .o_dma_wr_addr(d_wa), .o_dma_wr_size(d_ws),
    .i_dma_rd_done(rd_done), .i_dma_wr_done(wr_done),
    .o_dma_rd_en(d_ren), .o_dma_wr_en(d_wen),
    .i_dma_empty(d_empty), .i_dma_full(d_full), .o_dma_wr_data(d_wd),
    .o_busy(busy), .o_owner(owner), .o_job_cycles(jc)
  );

  task automatic post_req(input int n, input logic [AW:0] r_sz, input logic [AW:0] w_sz);
    logic [63:0] t;
    t = {$urandom, $urandom}; ra[n] = t[AW-1:0];
    t = {$urandom, $urandom}; wa[n] = t[AW-1:0];
    rs[n] = r_sz;
    ws[n] = w_sz;
    v[n]  = 1'b1;
  endtask

  // returns the cycle index of the accept, or -1 if ready never came
  task automatic wait_ready(input int n, output int a);
    int k;
    k = 0;
    #1;
    while (!rdy[n] && k < 60) begin @(negedge clk); #1; k++; end
    n_tests++;
    if (rdy[n] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_req%0d: ready=%0b required 1", n, rdy[n]);
      a = -1;
    end else begin
      a = cyc;
    end
  endtask

  task automatic run_job(input int n, input int r_sz, input int w_sz, input int lr, input int lw);
    int a, exp_end, k;
    bit seen;
    logic [AW-1:0] e_ra, e_wa;
    logic [CW-1:0] e_jc;
    lat_rd = lr; lat_wr = lw;
    @(negedge clk);
    post_req(n, (AW+1)'(r_sz), (AW+1)'(w_sz));
    e_ra = ra[n]; e_wa = wa[n];
    wait_ready(n, a);
    if (a < 0) begin v[n] = 1'b0; return; end
    @(negedge clk); v[n] = 1'b0; #1;
    n_tests++;
    if ({rd_go, wr_go} !== {r_sz != 0, w_sz != 0}) begin
      n_fail++; $display("FAIL go_pulses: got %b required %b", {rd_go, wr_go}, {r_sz != 0, w_sz != 0});
    end
    n_tests++;
    if (d_ra !== e_ra || d_wa !== e_wa || d_rs !== (AW+1)'(r_sz) || d_ws !== (AW+1)'(w_sz)) begin
      n_fail++; $display("FAIL job_fields: got rs=%0d ws=%0d required rs=%0d ws=%0d", d_rs, d_ws, r_sz, w_sz);
    end
    n_tests++;
    if (owner !== n[0] || busy !== 1'b1) begin
      n_fail++; $display("FAIL owner_busy: got %0d/%0b required %0d/1", owner, busy, n);
    end
    exp_end = a + G + 2;
    if (r_sz != 0 && a + 2 + lr > exp_end) exp_end = a + 2 + lr;
    if (w_sz != 0 && a + 2 + lw > exp_end) exp_end = a + 2 + lw;
    e_jc = (exp_end - a > 15) ? 4'hF : CW'(exp_end - a);
    seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk); #1; k++;
      if (cmpl[0] || cmpl[1]) seen = 1'b1;
    end
    n_tests++;
    if (!seen || cyc != exp_end + 1) begin
      n_fail++; $display("FAIL cmpl_cycle: got %0d (seen=%0b) required %0d", cyc - a, seen, exp_end + 1 - a);
    end
    n_tests++;
    if ({cmpl[1], cmpl[0]} !== ((n == 1) ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL cmpl_target: got %b for req%0d", {cmpl[1], cmpl[0]}, n);
    end
    n_tests++;
    if (jc !== e_jc) begin
      n_fail++; $display("FAIL job_cycles: got %0d required %0d", jc, e_jc);
    end
    @(negedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_cmpl: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (busy !== 1'b0 || owner !== 1'b0 || jc !== '0 || {rd_go, wr_go, cmpl[0], cmpl[1]} !== 4'b0) begin
      n_fail++; $display("FAIL reset_status: busy=%0b owner=%0b jc=%0d go/cmpl=%b required all 0",
                         busy, owner, jc, {rd_go, wr_go, cmpl[0], cmpl[1]});
    end
    n_tests++;
    if (d_ra !== '0 || d_rs !== '0 || d_wa !== '0 || d_ws !== '0) begin
      n_fail++; $display("FAIL reset_fields: rs=%0d ws=%0d required 0", d_rs, d_ws);
    end
    n_tests++;
    if ({emp[0], ful[0], emp[1], ful[1], d_ren, d_wen} !== 6'b111100) begin
      n_fail++; $display("FAIL reset_stream: got %b required 111100", {emp[0], ful[0], emp[1], ful[1], d_ren, d_wen});
    end
  endtask

  task automatic test_contention();
    int k;
    logic exp_w;
    lat_rd = 2; lat_wr = 2;
    @(negedge clk);
    post_req(0, 1, 1);
    post_req(1, 2, 0);
    exp_w = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      k = 0;
      while (!(rdy[0] || rdy[1]) && k < 60) begin @(negedge clk); #1; k++; end
      n_tests++;
      if ({rdy[1], rdy[0]} !== (exp_w ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL grant_%0d: ready=%b required winner %0d", j, {rdy[1], rdy[0]}, exp_w);
      end
      k = 0;
      do begin @(negedge clk); #1; k++; end while (!(cmpl[0] || cmpl[1]) && k < 40);
      n_tests++;
      if ({cmpl[1], cmpl[0]} !== (exp_w ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_cmpl_%0d: cmpl=%b required winner %0d", j, {cmpl[1], cmpl[0]}, exp_w);
      end
      exp_w = ~exp_w;
    end
    v[0] = 1'b0; v[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stale_done();
    int a;
    logic exp_c;
    man_mode = 1'b1; man_rd = 1'b1; man_wr = 1'b1;
    @(negedge clk);
    post_req(0, 4, 0);
    wait_ready(0, a);
    if (a < 0) begin v[0] = 1'b0; man_mode = 1'b0; return; end
    for (int c = a + 1; c <= a + G + 5; c++) begin
      @(negedge clk);
      v[0] = 1'b0;
      if (c == a + G + 2) man_rd = 1'b0;
      if (c == a + G + 4) man_rd = 1'b1;
      #1;
      exp_c = (c == a + G + 5);
      n_tests++;
      if (cmpl[0] !== exp_c) begin
        n_fail++; $display("FAIL stale_done_c%0d: cmpl0=%0b required %0b", c - a, cmpl[0], exp_c);
      end
    end
    n_tests++;
    if (jc !== CW'(G + 4)) begin
      n_fail++; $display("FAIL stale_job_cycles: got %0d required %0d", jc, G + 4);
    end
    man_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gating();
    int a, k;
    bit seen;
    logic [63:0] t;
    lat_rd = 9; lat_wr = 7;
    @(negedge clk);
    post_req(0, 3, 3);
    wait_ready(0, a);
    if (a < 0) begin v[0] = 1'b0; return; end
    seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk); k++;
      v[0] = 1'b0;
      post_req(1, 5, 5);
      ren[1] = 1'b1; wen[1] = 1'b1;
      ren[0] = $urandom_range(0, 1); wen[0] = $urandom_range(0, 1);
      d_empty = $urandom_range(0, 1); d_full = $urandom_range(0, 1);
      t = {$urandom, $urandom}; wd[0] = t;
      t = {$urandom, $urandom}; wd[1] = t;
      t = {$urandom, $urandom}; e_rd_data = t;
      #1;
      if (cmpl[0] || cmpl[1]) begin
        seen = 1'b1;
        v[1] = 1'b0;
        n_tests++;
        if ({emp[0], ful[0], emp[1], ful[1], d_ren, d_wen} !== 6'b111100) begin
          n_fail++; $display("FAIL gate_cmpl: got %b required 111100", {emp[0], ful[0], emp[1], ful[1], d_ren, d_wen});
        end
      end else begin
        n_tests++;
        if ({d_ren, d_wen, emp[0], ful[0], emp[1], ful[1], rdy[1]} !== {ren[0], wen[0], d_empty, d_full, 3'b110}) begin
          n_fail++; $display("FAIL gate_active: got %b required %b",
                             {d_ren, d_wen, emp[0], ful[0], emp[1], ful[1], rdy[1]}, {ren[0], wen[0], d_empty, d_full, 3'b110});
        end
        n_tests++;
        if (d_wd !== wd[0] || rd_data !== e_rd_data) begin
          n_fail++; $display("FAIL gate_data: wr=%h rd=%h required %h/%h", d_wd, rd_data, wd[0], e_rd_data);
        end
      end
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL gate_cmpl_timeout: seen=0 required 1"); end
    v[1] = 1'b0; ren[0] = 1'b0; wen[0] = 1'b0; ren[1] = 1'b0; wen[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_job($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(1, 16), $urandom_range(1, 16));
  endtask

  task automatic test_reset_mid_busy();
    int a, bad;
    lat_rd = 20; lat_wr = 20;
    @(negedge clk);
    post_req(1, 2, 2);
    wait_ready(1, a);
    if (a < 0) begin v[1] = 1'b0; return; end
    @(negedge clk); v[1] = 1'b0;
    repeat (G + 2) @(negedge clk);
    rst_n = 1'b0; #1;
    n_tests++;
    if (busy !== 1'b0 || owner !== 1'b0 || jc !== '0 || d_rs !== '0 || d_ws !== '0) begin
      n_fail++; $display("FAIL rst_mid_state: busy=%0b owner=%0b jc=%0d rs=%0d required 0", busy, owner, jc, d_rs);
    end
    bad = 0;
    repeat (25) begin @(negedge clk); #1; if (cmpl[0] || cmpl[1] || busy) bad++; end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_no_cmpl: %0d cycles with cmpl/busy, required 0", bad); end
    rst_n = 1'b1;
    post_req(0, 0, 0); #1;
    n_tests++;
    if (rdy[0] !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready_restored: ready=%0b busy=%0b required 1/0", rdy[0], busy);
    end
    @(negedge clk); v[0] = 1'b0;
    repeat (G + 4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; ra[i] = '0; rs[i] = '0; wa[i] = '0; ws[i] = '0;
      ren[i] = 1'b0; wen[i] = 1'b0; wd[i] = '0;
    end
    e_rd_data = '0; d_empty = 1'b0; d_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_contention();
    run_job(0, 4, 4, 5, 7);
    run_job(1, 0, 0, 3, 3);
    test_stale_done();
    test_gating();
    test_random();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
